sa_load_sequencer: RTL and testbench
====================================

// Module: sa_load_sequencer
// PURPOSE
//  Upstream sequencer for the 8x8 systolic-array wrapper. It accepts operand words on a valid/ready
//  stream and drives the wrapper's EN / RF_EN / WRITE / IDX / DIN / REG_SELECT inputs to fill the
//  X and W register-file banks. It then drops WRITE for a fixed compute window and pulses DONE.
//  It replaces hand-driven stimulus and is the only driver of the wrapper's control pins.
// PARAMETERS
//  DATA_W     16  operand width (matches DIN)
//  N          8   array dimension; banks REG_SELECT 0..N-1 = X rows, N..2N-1 = W columns (2N<=16)
//  DEPTH      32  entries per register (IDX range 0..DEPTH-1)
//  LAT_EXTRA  2   extra compute cycles beyond wavefront length
// PORTS
//  CLK         in   1       clock, all state on posedge
//  RSTN        in   1       asynchronous active-low reset
//  START       in   1       1-cycle request to begin a load+compute job
//  CFG_LEN     in   6       entries per register for this job, legal 1..DEPTH
//  S_VALID     in   1       operand word valid
//  S_READY     out  1       sequencer accepts word this cycle
//  S_DATA      in   DATA_W  operand word
//  EN          out  1       to wrapper EN: capture DIN/IDX/REG_SELECT into its buffer
//  RF_EN       out  1       to wrapper RF_EN: commit buffered word into register file
//  WRITE       out  1       to wrapper WRITE: 1 = load mode/array frozen, 0 = MATMUL runs
//  IDX         out  5       entry index of word on DIN
//  REG_SELECT  out  4       target register of word on DIN
//  DIN         out  DATA_W  operand word to wrapper
//  BUSY        out  1       job in progress (any state but IDLE)
//  DONE        out  1       1-cycle pulse at end of compute window
//  ERR         out  1       1-cycle pulse: START rejected for illegal CFG_LEN
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, WRITE=1, all other outputs 0, counters 0.
//  Reset mid-job abandons the job; partially loaded RF contents are undefined, no DONE issued.
//  All outputs registered. States: IDLE, LOAD, FLUSH, COMPUTE, FIN.
//  IDLE: WRITE=1, S_READY=0. START with CFG_LEN in 1..DEPTH -> latch LEN, clear REG/IDX counters,
//   go LOAD. START with CFG_LEN=0 or >DEPTH -> stay IDLE, ERR=1 next cycle.
//   START outside IDLE is ignored (no ERR).
//  LOAD: S_READY=1. Beat = S_VALID&S_READY. On beat, next cycle: EN=1, DIN=S_DATA,
//   REG_SELECT/IDX = current counters; otherwise EN=0 and DIN/IDX/REG_SELECT hold.
//   RF_EN = EN delayed 1 cycle, matching the wrapper's input buffer stage.
//   Order: REG_SELECT fastest, 0..2N-1, wraps to 0 and increments IDX. Total beats = LEN*2N.
//   Beat with REG_SELECT=2N-1 and IDX=LEN-1 is last: S_READY=0 from next cycle, go FLUSH.
//  FLUSH: 2 cycles, WRITE=1. Lets the final EN and RF_EN land; then go COMPUTE.
//  COMPUTE: WRITE=0, EN=0, RF_EN=0. Lasts exactly C = LEN + 3N - 2 + LAT_EXTRA cycles
//   (cycle counter counts 0..C-1, 7 bits wide), then go FIN.
//  FIN: WRITE=1, DONE=1 for one cycle, BUSY=0 from next cycle, return to IDLE.
//   START in FIN is ignored.
//  BUSY=1 from the cycle after an accepted START through FIN inclusive.
//  S_VALID gaps stall LOAD indefinitely; no timeout. Words are never dropped or duplicated.
//  WRITE is never 0 outside COMPUTE.
// TESTING
//  T1 reset: RSTN low mid-COMPUTE -> WRITE=1, BUSY=0, S_READY=0 the same cycle; no DONE.
//  T2 LEN=1, N=8, continuous valid, data 0..15 -> 16 EN pulses with REG_SELECT 0..15, IDX=0,
//     RF_EN lagging EN by 1; WRITE=0 for exactly 1+22+2=25 cycles; one DONE.
//  T3 LEN=4, valid toggling every cycle -> 64 beats; IDX steps 0..3 after each REG_SELECT 15;
//     DIN matches the input sequence exactly.
//  T4 START with CFG_LEN=0, then with 33 -> ERR pulses, BUSY stays 0, no EN.
//  T5 START pulsed during LOAD and during FIN -> ignored; the job completes with a single DONE.
//  T6 back-to-back jobs (START the cycle after DONE) -> second job is accepted and its counters
//     restart from 0.

Source files
------------

// File: rtl/sa_load_sequencer.sv
// sa_load_sequencer
//   Drives the 8x8 systolic-array wrapper's control pins. It streams operand
//   words from a valid/ready input into the X (REG_SELECT 0..N-1) and
//   W (REG_SELECT N..2N-1) register banks. It then drops WRITE for a fixed
//   compute window and pulses DONE.
//
// Ports
//   CLK, RSTN            clock / async active-low reset
//   START, CFG_LEN       job request and entries per register (legal 1..DEPTH)
//   S_VALID/S_READY/S_DATA  operand stream
//   EN, RF_EN, WRITE, IDX, REG_SELECT, DIN   wrapper control/data
//   BUSY, DONE, ERR      status (DONE/ERR are 1-cycle pulses)
//
// All outputs are registered. Level-type outputs (S_READY, WRITE, BUSY, DONE)
// are computed from the next state, so they line up with the state register.
module sa_load_sequencer #(
    parameter int DATA_W    = 16,
    parameter int N         = 8,
    parameter int DEPTH     = 32,
    parameter int LAT_EXTRA = 2
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START,
    input  logic [5:0]        CFG_LEN,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic [DATA_W-1:0] S_DATA,
    output logic              EN,
    output logic              RF_EN,
    output logic              WRITE,
    output logic [4:0]        IDX,
    output logic [3:0]        REG_SELECT,
    output logic [DATA_W-1:0] DIN,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    localparam logic [3:0] RS_LAST = 4'(2 * N - 1);
    localparam logic [5:0] LEN_MAX = 6'(DEPTH);
    // The last COMPUTE count is LEN + 3N - 2 + LAT_EXTRA - 1.
    localparam logic [6:0] C_OFF   = 7'(3 * N - 2 + LAT_EXTRA - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_COMPUTE,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          len_q, len_d;
    logic [3:0]          rs_cnt_q, rs_cnt_d;
    logic [4:0]          idx_cnt_q, idx_cnt_d;
    logic [6:0]          cyc_q, cyc_d;
    logic                s_ready_q, s_ready_d;
    logic                en_q, en_d;
    logic                rf_en_q, rf_en_d;
    logic                write_q, write_d;
    logic [4:0]          idx_q, idx_d;
    logic [3:0]          reg_sel_q, reg_sel_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic beat, last_beat, compute_last;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rs_cnt_d  = rs_cnt_q;
        idx_cnt_d = idx_cnt_q;
        cyc_d     = cyc_q;
        en_d      = 1'b0;
        rf_en_d   = en_q;         // commit follows capture by one cycle
        idx_d     = idx_q;
        reg_sel_d = reg_sel_q;
        din_d     = din_q;
        err_d     = 1'b0;

        beat         = (state_q == S_LOAD) && S_VALID && s_ready_q;
        last_beat    = beat && (rs_cnt_q == RS_LAST) &&
                       ({1'b0, idx_cnt_q} == (len_q - 6'd1));
        compute_last = (cyc_q == ({1'b0, len_q} + C_OFF));

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (CFG_LEN != 6'd0 && CFG_LEN <= LEN_MAX) begin
                        len_d     = CFG_LEN;
                        rs_cnt_d  = '0;
                        idx_cnt_d = '0;
                        state_d   = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (beat) begin
                    en_d      = 1'b1;
                    din_d     = S_DATA;
                    reg_sel_d = rs_cnt_q;
                    idx_d     = idx_cnt_q;
                    // REG_SELECT runs fastest; IDX steps on its wrap
                    if (rs_cnt_q == RS_LAST) begin
                        rs_cnt_d  = '0;
                        idx_cnt_d = idx_cnt_q + 5'd1;
                    end else begin
                        rs_cnt_d  = rs_cnt_q + 4'd1;
                    end
                    if (last_beat) begin
                        state_d = S_FLUSH;
                        cyc_d   = '0;
                    end
                end
            end
            S_FLUSH: begin
                // Two cycles: the final EN lands, then its RF_EN
                if (cyc_q == 7'd1) begin
                    state_d = S_COMPUTE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 7'd1;
                end
            end
            S_COMPUTE: begin
                if (compute_last) begin
                    state_d = S_FIN;
                end else begin
                    cyc_d = cyc_q + 7'd1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        s_ready_d = (state_d == S_LOAD);
        write_d   = (state_d != S_COMPUTE);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_FIN);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            rs_cnt_q  <= '0;
            idx_cnt_q <= '0;
            cyc_q     <= '0;
            s_ready_q <= 1'b0;
            en_q      <= 1'b0;
            rf_en_q   <= 1'b0;
            write_q   <= 1'b1;
            idx_q     <= '0;
            reg_sel_q <= '0;
            din_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rs_cnt_q  <= rs_cnt_d;
            idx_cnt_q <= idx_cnt_d;
            cyc_q     <= cyc_d;
            s_ready_q <= s_ready_d;
            en_q      <= en_d;
            rf_en_q   <= rf_en_d;
            write_q   <= write_d;
            idx_q     <= idx_d;
            reg_sel_q <= reg_sel_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign S_READY    = s_ready_q;
    assign EN         = en_q;
    assign RF_EN      = rf_en_q;
    assign WRITE      = write_q;
    assign IDX        = idx_q;
    assign REG_SELECT = reg_sel_q;
    assign DIN        = din_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_sa_load_sequencer.sv
// Bench for sa_load_sequencer: a table of jobs plus hand-written sequences
// for reset mid-compute, START pokes during LOAD/FIN and back-to-back jobs.
module tb_sa_load_sequencer;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        START = 1'b0;
    logic [5:0]  CFG_LEN = '0;
    logic        S_VALID = 1'b0;
    logic [15:0] S_DATA = '0;
    logic        S_READY, EN, RF_EN, WRITE, BUSY, DONE, ERR;
    logic [4:0]  IDX;
    logic [3:0]  REG_SELECT;
    logic [15:0] DIN;

    sa_load_sequencer dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .CFG_LEN(CFG_LEN),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
        .EN(EN), .RF_EN(RF_EN), .WRITE(WRITE), .IDX(IDX),
        .REG_SELECT(REG_SELECT), .DIN(DIN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- output monitor (samples on negedge) ----------------
    int en_cnt = 0, rf_cnt = 0, w0_cnt = 0, win_cnt = 0, done_cnt = 0;
    int err_cnt = 0, seq_bad = 0, lag_bad = 0, viol = 0, busy_cnt = 0;
    logic        prev_en = 1'b0;
    logic        prev_write = 1'b1;
    logic [24:0] expq[$];
    logic [24:0] mon_e;

    always @(negedge CLK) begin
        if (EN) begin
            en_cnt++;
            if (expq.size() == 0) seq_bad++;
            else begin
                mon_e = expq.pop_front();
                if ({IDX, REG_SELECT, DIN} !== mon_e) seq_bad++;
            end
        end
        if (RF_EN) rf_cnt++;
        if (RF_EN !== prev_en) lag_bad++;
        if (!WRITE) begin
            w0_cnt++;
            if (prev_write) win_cnt++;
            if (EN || RF_EN || !BUSY) viol++;
        end
        if (DONE) begin
            done_cnt++;
            if (!WRITE) viol++;
        end
        if (ERR) err_cnt++;
        if (BUSY) busy_cnt++;
        prev_en    = EN;
        prev_write = WRITE;
    end

    typedef struct {
        int en, rf, w0, win, done, err, seq, lag, viol, busy;
    } snap_t;

    function automatic snap_t take();
        snap_t s;
        s.en = en_cnt;  s.rf = rf_cnt;   s.w0 = w0_cnt;   s.win = win_cnt;
        s.done = done_cnt; s.err = err_cnt; s.seq = seq_bad; s.lag = lag_bad;
        s.viol = viol;  s.busy = busy_cnt;
        return s;
    endfunction

    // ---------------- job table ----------------
    typedef struct {
        logic [5:0]  len;
        int          mode;      // 0 continuous, 1 toggling, 2 random gaps
        logic [15:0] seed;
        int          exp_err;
        int          exp_beats; // LEN*16
        int          exp_w0;    // LEN + 3*8 - 2 + 2
        int          exp_done;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(negedge CLK); #1;
    endtask

    task automatic run_job(input vec_t v, input bit poke, input string tag);
        snap_t s0, s1;
        int k = 0;
        int guard = 0;
        bit poked = 1'b0;
        s0 = take();
        step();
        START = 1'b1; CFG_LEN = v.len;
        step();
        START = 1'b0;
        if (v.exp_err == 0) begin
            check({tag, ":busy_after_start"}, BUSY, 1);
            while (k < v.exp_beats && guard < 20000) begin
                case (v.mode)
                    0:       S_VALID = 1'b1;
                    1:       S_VALID = guard[0];
                    default: S_VALID = ($urandom_range(0, 2) != 0);
                endcase
                S_DATA = v.seed + 16'(k);
                if (poke && k == 5 && !poked) begin
                    START = 1'b1; CFG_LEN = 6'd3; poked = 1'b1;
                end else begin
                    START = 1'b0;
                end
                if (S_VALID && S_READY) begin
                    expq.push_back({5'(k / 16), 4'(k % 16), S_DATA});
                    k++;
                end
                step();
                guard++;
            end
            S_VALID = 1'b0;
            START   = 1'b0;
            check({tag, ":beats_accepted"}, k, v.exp_beats);
            check({tag, ":ready_low_after_load"}, S_READY, 0);
            guard = 0;
            while (!DONE && guard < 300) begin
                step();
                guard++;
            end
            check({tag, ":done_seen"}, DONE, 1);
            if (poke) begin
                // DONE high means the sequencer sits in FIN at the next edge
                START = 1'b1; CFG_LEN = 6'd3;
                step();
                START = 1'b0;
            end
        end else begin
            repeat (3) step();
            check({tag, ":busy_stays_0"}, BUSY, 0);
        end
        s1 = take();
        check({tag, ":err_pulses"},   s1.err - s0.err, v.exp_err);
        check({tag, ":en_pulses"},    s1.en - s0.en, v.exp_beats);
        check({tag, ":rf_en_pulses"}, s1.rf - s0.rf, v.exp_beats);
        check({tag, ":din_idx_rs"},   s1.seq - s0.seq, 0);
        check({tag, ":rf_en_lag"},    s1.lag - s0.lag, 0);
        check({tag, ":write0_cycles"}, s1.w0 - s0.w0, v.exp_w0);
        check({tag, ":write0_windows"}, s1.win - s0.win, (v.exp_w0 > 0) ? 1 : 0);
        check({tag, ":done_pulses"},  s1.done - s0.done, v.exp_done);
        check({tag, ":write_rules"},  s1.viol - s0.viol, 0);
        check({tag, ":queue_drained"}, expq.size(), 0);
        if (v.exp_err != 0) check({tag, ":busy_cycles"}, s1.busy - s0.busy, 0);
    endtask

    initial begin
        snap_t s0, s1;
        int guard;
        vecs[0] = '{6'd1,  0, 16'h0000, 0, 16,  25, 1};
        vecs[1] = '{6'd4,  1, 16'h1000, 0, 64,  28, 1};
        vecs[2] = '{6'd0,  0, 16'h0000, 1, 0,   0,  0};
        vecs[3] = '{6'd33, 0, 16'h0000, 1, 0,   0,  0};
        vecs[4] = '{6'd2,  2, 16'hA5A0, 0, 32,  26, 1};
        vecs[5] = '{6'd32, 0, 16'h4000, 0, 512, 56, 1};
        vecs[6] = '{6'd1,  0, 16'h7F00, 0, 16,  25, 1};

        // reset state
        #12;
        check("reset:write", WRITE, 1);
        check("reset:others", {S_READY, EN, RF_EN, BUSY, DONE, ERR, IDX, REG_SELECT, DIN}, 0);
        step();
        RSTN = 1'b1;
        repeat (2) step();

        // table jobs; 5 -> 6 run back to back (START the cycle after DONE)
        for (int i = 0; i < 7; i++) run_job(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // START pokes during LOAD and FIN are ignored
        run_job('{6'd2, 0, 16'h3300, 0, 32, 26, 1}, 1'b1, "poke");
        repeat (3) step();
        check("poke:fin_start_ignored", BUSY, 0);

        // reset in the middle of COMPUTE
        s0 = take();
        START = 1'b1; CFG_LEN = 6'd1;
        step();
        START = 1'b0;
        guard = 0;
        while (WRITE && guard < 200) begin
            S_VALID = S_READY;
            S_DATA  = 16'h5500 + 16'(guard);
            if (S_VALID && S_READY)
                expq.push_back({5'd0, 4'(expq.size() + (en_cnt - s0.en)), S_DATA});
            step();
            guard++;
        end
        S_VALID = 1'b0;
        check("rst:reached_compute", WRITE, 0);
        repeat (5) step();
        RSTN = 1'b0;
        #1;
        check("rst:write_now", WRITE, 1);
        check("rst:busy_now", BUSY, 0);
        check("rst:ready_now", S_READY, 0);
        step();
        RSTN = 1'b1;
        repeat (40) step();
        s1 = take();
        check("rst:no_done", s1.done - s0.done, 0);
        check("rst:en_pulses", s1.en - s0.en, 16);
        check("rst:din_idx_rs", s1.seq - s0.seq, 0);
        check("rst:idle_after", BUSY, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
